// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for rggen register wrappers: bus status codes, the
// register handshake state type and beat-index sizing.
package rggen_rtl_pkg;

  localparam logic [1:0] StatusOkay   = 2'b00;
  localparam logic [1:0] StatusSlverr = 2'b10;

  typedef enum logic {StIdle, StAck} register_state_e;

  // Beat index is at least one bit wide so single-beat registers still elaborate.
  function automatic int unsigned beat_index_width(int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/rggen_register_beat_buffer.sv
// Write-merge buffer, pending strobe mask and optional read snapshot for a multi-beat register.
// Snapshot ports exist only when RGGEN_WIDE_REGISTER_ATOMIC_READ_EN is defined.
module rggen_register_beat_buffer
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned BEATS     = 2
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_merge,
  input  logic                                    i_clear,
  input  logic [beat_index_width(BEATS)-1:0]      i_beat,
  input  logic [BUS_WIDTH-1:0]                    i_data,
  input  logic [BUS_WIDTH-1:0]                    i_strobe,
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_READ_EN
  input  logic                                    i_snapshot_en,
  input  logic [BEATS*BUS_WIDTH-1:0]              i_snapshot_data,
  output logic [BEATS*BUS_WIDTH-1:0]              o_snapshot,
`endif
  output logic [BEATS*BUS_WIDTH-1:0]              o_buffer_data,
  output logic [BEATS*BUS_WIDTH-1:0]              o_pending_mask
);

  localparam int unsigned BeatIndexWidth = beat_index_width(BEATS);

  if (BEATS > 1) begin : g_buffer
    localparam int unsigned BufWidth = (BEATS - 1) * BUS_WIDTH;

    logic [BufWidth-1:0] buf_q, buf_d;
    logic [BufWidth-1:0] pending_q, pending_d;

    always_comb begin
      buf_d     = buf_q;
      pending_d = pending_q;
      if (i_clear) begin
        buf_d     = '0;
        pending_d = '0;
      end else if (i_merge) begin
        for (int i = 0; i < BEATS - 1; i++) begin
          if (i_beat == BeatIndexWidth'(i)) begin
            buf_d[i*BUS_WIDTH+:BUS_WIDTH] =
              (buf_q[i*BUS_WIDTH+:BUS_WIDTH] & ~i_strobe) | (i_data & i_strobe);
            pending_d[i*BUS_WIDTH+:BUS_WIDTH] = pending_q[i*BUS_WIDTH+:BUS_WIDTH] | i_strobe;
          end
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        buf_q     <= '0;
        pending_q <= '0;
      end else begin
        buf_q     <= buf_d;
        pending_q <= pending_d;
      end
    end

    // The last beat is never buffered; it arrives with the commit itself.
    assign o_buffer_data  = {{BUS_WIDTH{1'b0}}, buf_q};
    assign o_pending_mask = {{BUS_WIDTH{1'b0}}, pending_q};
  end else begin : g_no_buffer
    assign o_buffer_data  = '0;
    assign o_pending_mask = '0;
  end

`ifdef RGGEN_WIDE_REGISTER_ATOMIC_READ_EN
  logic [BEATS*BUS_WIDTH-1:0] snapshot_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snapshot_q <= '0;
    end else if (i_snapshot_en) begin
      snapshot_q <= i_snapshot_data;
    end
  end

  assign o_snapshot = snapshot_q;
`endif

endmodule

// File: rtl/rggen_wide_register.sv
// Register wrapper for a register wider than the bus: buffers beats and commits atomically.
// Define RGGEN_WIDE_REGISTER_ATOMIC_READ_EN to snapshot the register on beat-0 reads.
module rggen_wide_register
  import rggen_rtl_pkg::*;
#(
  parameter bit                      READABLE       = 1'b1,
  parameter bit                      WRITABLE       = 1'b1,
  parameter int unsigned             ADDRESS_WIDTH  = 8,
  parameter bit [ADDRESS_WIDTH-1:0]  OFFSET_ADDRESS = '0,
  parameter int unsigned             BUS_WIDTH      = 32,
  parameter int unsigned             DATA_WIDTH     = 2 * BUS_WIDTH,
  parameter bit [DATA_WIDTH-1:0]     VALID_BITS     = '1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_register_valid,
  input  logic                     i_register_write,
  input  logic [ADDRESS_WIDTH-1:0] i_register_address,
  input  logic [BUS_WIDTH-1:0]     i_register_write_data,
  input  logic [BUS_WIDTH-1:0]     i_register_strobe,
  output logic                     o_register_active,
  output logic                     o_register_ready,
  output logic [1:0]               o_register_status,
  output logic [BUS_WIDTH-1:0]     o_register_read_data,
  output logic [DATA_WIDTH-1:0]    o_register_value,
  output logic                     o_bit_field_write_valid,
  output logic                     o_bit_field_read_valid,
  output logic [DATA_WIDTH-1:0]    o_bit_field_mask,
  output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
  input  logic [DATA_WIDTH-1:0]    i_bit_field_value
);

  localparam int unsigned BEATS          = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned BeatIndexWidth = beat_index_width(BEATS);
  localparam int unsigned ByteShift      = $clog2(BUS_WIDTH / 8);
  localparam int unsigned LastShift      = (BEATS - 1) * BUS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0]      RangeSize = (ADDRESS_WIDTH+1)'(BEATS * BUS_WIDTH / 8);
  localparam logic [BeatIndexWidth-1:0]   LastBeat  = BeatIndexWidth'(BEATS - 1);

  logic [ADDRESS_WIDTH-1:0]  offset;
  logic                      hit;
  logic [BeatIndexWidth-1:0] beat;
  logic                      accept, merge, commit, read_access, read_pulse;
  logic [DATA_WIDTH-1:0]     buffer_data, pending_mask, commit_data, commit_mask, read_mask;
  logic [BUS_WIDTH-1:0]      live_slice, read_slice, read_data_d;
  logic [1:0]                status_d;

  register_state_e           state_q;
  logic                      ready_q;
  logic [1:0]                status_q;
  logic [BUS_WIDTH-1:0]      read_data_q;

  // Address wraps below the offset are rejected by the explicit >= compare.
  assign offset = i_register_address - OFFSET_ADDRESS;
  assign hit    = (i_register_address >= OFFSET_ADDRESS) && ({1'b0, offset} < RangeSize);
  assign beat   = BeatIndexWidth'(offset >> ByteShift);

  assign o_register_active = i_register_valid && hit;
  assign accept            = (state_q == StIdle) && o_register_active;
  assign merge             = accept && i_register_write && WRITABLE && (beat != LastBeat);
  assign commit            = accept && i_register_write && WRITABLE && (beat == LastBeat);
  assign read_access       = accept && !i_register_write && READABLE;

  assign commit_data = buffer_data | (DATA_WIDTH'(i_register_write_data) << LastShift);
  assign commit_mask = pending_mask | (DATA_WIDTH'(i_register_strobe) << LastShift);
  assign live_slice  = BUS_WIDTH'(i_bit_field_read_data >> (int'(beat) * BUS_WIDTH));

`ifdef RGGEN_WIDE_REGISTER_ATOMIC_READ_EN
  logic [DATA_WIDTH-1:0] snapshot;

  assign read_pulse = read_access && (beat == '0);
  assign read_mask  = '1;
  assign read_slice = (beat == '0) ? live_slice
                                   : BUS_WIDTH'(snapshot >> (int'(beat) * BUS_WIDTH));
`else
  assign read_pulse = read_access;
  assign read_mask  = DATA_WIDTH'({BUS_WIDTH{1'b1}}) << (int'(beat) * BUS_WIDTH);
  assign read_slice = live_slice;
`endif

  rggen_register_beat_buffer #(
    .BUS_WIDTH (BUS_WIDTH),
    .BEATS     (BEATS)
  ) u_beat_buffer (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_merge         (merge),
    .i_clear         (commit),
    .i_beat          (beat),
    .i_data          (i_register_write_data),
    .i_strobe        (i_register_strobe),
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_READ_EN
    .i_snapshot_en   (read_pulse),
    .i_snapshot_data (i_bit_field_read_data),
    .o_snapshot      (snapshot),
`endif
    .o_buffer_data   (buffer_data),
    .o_pending_mask  (pending_mask)
  );

  always_comb begin
    o_bit_field_mask = '0;
    if (commit) begin
      o_bit_field_mask = commit_mask & VALID_BITS;
    end else if (read_pulse) begin
      o_bit_field_mask = read_mask & VALID_BITS;
    end
  end

  assign o_bit_field_write_valid = commit;
  assign o_bit_field_read_valid  = read_pulse;
  assign o_bit_field_write_data  = commit_data;
  assign o_register_value        = i_bit_field_value & VALID_BITS;

  always_comb begin
    status_d    = StatusOkay;
    read_data_d = '0;
    if (i_register_write) begin
      if (!WRITABLE) status_d = StatusSlverr;
    end else if (!READABLE) begin
      status_d = StatusSlverr;
    end else begin
      read_data_d = read_slice;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      status_q    <= StatusOkay;
      read_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= accept;
          if (accept) begin
            state_q     <= StAck;
            status_q    <= status_d;
            read_data_q <= read_data_d;
          end
        end
        StAck: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_register_ready     = ready_q;
  assign o_register_status    = status_q;
  assign o_register_read_data = read_data_q;

endmodule

// File: tb/tb_rggen_wide_register.sv
// Bench for rggen_wide_register (32-bit bus, 64-bit register at 0x10), readable and
// write-only-read-error instances; expected responses are queued and popped on ready.
module tb_rggen_wide_register;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] wdata = '0, strobe = '0;
  logic [63:0] bf = '0;

  logic        active0, ready0, wv0, rv0;
  logic [1:0]  status0;
  logic [31:0] rdata0;
  logic [63:0] value0, mask0, bwdata0;
  logic        active1, ready1, wv1, rv1;
  logic [1:0]  status1;
  logic [31:0] rdata1;
  logic [63:0] value1, mask1, bwdata1;

  int checks = 0;
  int failures = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  rggen_wide_register #(
    .READABLE (1'b1), .WRITABLE (1'b1), .ADDRESS_WIDTH (8), .OFFSET_ADDRESS (8'h10),
    .BUS_WIDTH (32), .DATA_WIDTH (64), .VALID_BITS ('1)
  ) u_dut (
    .i_clk (clk), .i_rst_n (rst_n), .i_register_valid (valid0), .i_register_write (write),
    .i_register_address (address), .i_register_write_data (wdata),
    .i_register_strobe (strobe), .o_register_active (active0), .o_register_ready (ready0),
    .o_register_status (status0), .o_register_read_data (rdata0),
    .o_register_value (value0), .o_bit_field_write_valid (wv0),
    .o_bit_field_read_valid (rv0), .o_bit_field_mask (mask0),
    .o_bit_field_write_data (bwdata0), .i_bit_field_read_data (bf),
    .i_bit_field_value (bf)
  );

  rggen_wide_register #(
    .READABLE (1'b0), .WRITABLE (1'b1), .ADDRESS_WIDTH (8), .OFFSET_ADDRESS (8'h10),
    .BUS_WIDTH (32), .DATA_WIDTH (64), .VALID_BITS ('1)
  ) u_dut_wo (
    .i_clk (clk), .i_rst_n (rst_n), .i_register_valid (valid1), .i_register_write (write),
    .i_register_address (address), .i_register_write_data (wdata),
    .i_register_strobe (strobe), .o_register_active (active1), .o_register_ready (ready1),
    .o_register_status (status1), .o_register_read_data (rdata1),
    .o_register_value (value1), .o_bit_field_write_valid (wv1),
    .o_bit_field_read_valid (rv1), .o_bit_field_mask (mask1),
    .o_bit_field_write_data (bwdata1), .i_bit_field_read_data (bf),
    .i_bit_field_value (bf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; pulse expectations are checked during the accept cycle and
  // the response is checked against the scoreboard when ready rises.
  task automatic access(input bit sel, input logic [7:0] addr, input bit wr,
                        input logic [31:0] d, input logic [31:0] s,
                        input logic [1:0] e_status, input logic [31:0] e_rdata,
                        input bit e_wv, input bit e_rv,
                        input logic [63:0] e_mask, input logic [63:0] e_wdata);
    resp_t e;
    bit    seen;
    int    lat;
    logic  rdy;
    @(posedge clk); #1;
    address = addr; write = wr; wdata = d; strobe = s;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    exp_q.push_back('{status: e_status, rdata: e_rdata});
    @(negedge clk);
    check_eq("active", 64'(sel ? active1 : active0), 64'(1));
    check_eq("write_valid", 64'(sel ? wv1 : wv0), 64'(e_wv));
    check_eq("read_valid", 64'(sel ? rv1 : rv0), 64'(e_rv));
    if (e_wv || e_rv) check_eq("bf_mask", sel ? mask1 : mask0, e_mask);
    if (e_wv) check_eq("bf_write_data", sel ? bwdata1 : bwdata0, e_wdata);
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      rdy = sel ? ready1 : ready0;
      if (rdy) begin
        seen = 1'b1;
        lat = i;
      end
    end
    e = exp_q.pop_front();
    if (seen) begin
      check_eq("ready_latency", 64'(lat), 64'(0));
      check_eq("status", 64'(sel ? status1 : status0), 64'(e.status));
      check_eq("read_data", 64'(sel ? rdata1 : rdata0), 64'(e.rdata));
    end else begin
      check_eq("ready_timeout", 64'(0), 64'(1));
    end
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    check_eq("ready_one_cycle", 64'(sel ? ready1 : ready0), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(ready0), 64'(0));
    check_eq("rst_status", 64'(status0), 64'(0));
    check_eq("rst_read_data", 64'(rdata0), 64'(0));
    check_eq("rst_write_valid", 64'(wv0), 64'(0));
    check_eq("rst_read_valid", 64'(rv0), 64'(0));
    rst_n = 1'b1;

    // Full two-beat write commits once, on the last beat.
    access(0, 8'h10, 1, 32'h11223344, 32'hFFFF_FFFF, 2'b00, 32'h0, 0, 0, 64'h0, 64'h0);
    access(0, 8'h14, 1, 32'hAABBCCDD, 32'hFFFF_FFFF, 2'b00, 32'h0, 1, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hAABBCCDD_11223344);

    // Last beat alone carries only its own strobes.
    access(0, 8'h14, 1, 32'h12345678, 32'h0000_FFFF, 2'b00, 32'h0, 1, 0,
           64'h0000_FFFF_0000_0000, 64'h12345678_00000000);

    // Later write to a buffered beat wins per strobe bit; pending strobes accumulate.
    access(0, 8'h10, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0, 0, 0, 64'h0, 64'h0);
    access(0, 8'h10, 1, 32'h0000_0000, 32'h0000_FFFF, 2'b00, 32'h0, 0, 0, 64'h0, 64'h0);
    access(0, 8'h14, 1, 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0, 1, 0,
           64'h0000_0000_FFFF_FFFF, 64'h00000000_FFFF0000);

    // Coherent read across beats.
    bf = 64'h01234567_89ABCDEF;
    @(negedge clk);
    check_eq("register_value", value0, 64'h01234567_89ABCDEF);
`ifdef RGGEN_WIDE_REGISTER_ATOMIC_READ_EN
    access(0, 8'h10, 0, 32'h0, 32'h0, 2'b00, 32'h89ABCDEF, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    bf = 64'h0;
    access(0, 8'h14, 0, 32'h0, 32'h0, 2'b00, 32'h01234567, 0, 0, 64'h0, 64'h0);
`else
    access(0, 8'h10, 0, 32'h0, 32'h0, 2'b00, 32'h89ABCDEF, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'h0);
    bf = 64'h0;
    access(0, 8'h14, 0, 32'h0, 32'h0, 2'b00, 32'h00000000, 0, 1, 64'hFFFF_FFFF_0000_0000, 64'h0);
`endif

    // Reset between beats drops the buffered first beat.
    access(0, 8'h10, 1, 32'hDEADBEEF, 32'hFFFF_FFFF, 2'b00, 32'h0, 0, 0, 64'h0, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", 64'(ready0), 64'(0));
    access(0, 8'h14, 1, 32'h55AA55AA, 32'hFFFF_FFFF, 2'b00, 32'h0, 1, 0,
           64'hFFFF_FFFF_0000_0000, 64'h55AA55AA_00000000);

    // Read of a non-readable register errors with zero data and no pulse.
    bf = 64'hCAFEF00D_12345678;
    access(1, 8'h10, 0, 32'h0, 32'h0, 2'b10, 32'h0, 0, 0, 64'h0, 64'h0);

    // Address just past the register is a miss.
    @(posedge clk); #1;
    address = 8'h18; write = 1'b1; wdata = 32'hFFFF_FFFF; strobe = 32'hFFFF_FFFF;
    valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("miss_active", 64'(active0), 64'(0));
      check_eq("miss_ready", 64'(ready0), 64'(0));
      check_eq("miss_write_valid", 64'(wv0), 64'(0));
      check_eq("miss_read_valid", 64'(rv0), 64'(0));
    end
    @(posedge clk); #1;
    valid0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
